// File: rtl/dmem_responder.sv
// Data-memory responder: multi-cycle word array with split misaligned access.
// Ports: clk/rst, load_mem/store_mem/size/sign/addr/wdata in; busy/done/err/rdata out.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_mem,
  input  logic        store_mem,
  input  logic [2:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ld_q, ld_d;
  logic        inv_q, inv_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          req;
  logic          inv_in;
  logic [1:0]    off;
  logic [AW-1:0] idx0;
  logic [AW-1:0] idx1;
  logic [31:0]   rd0;
  logic [31:0]   rd1;
  logic          split;
  logic          last;
  logic [3:0]    lanes;
  logic [7:0]    be8;
  logic [63:0]   wd64;
  logic          wr0;
  logic          wr1;

  assign req    = load_mem | store_mem;
  assign inv_in = !(size == 3'd1 || size == 3'd2 || size == 3'd4)
                | (load_mem & store_mem);

  assign off  = addr_q[1:0];
  assign idx0 = addr_q[AW+1:2];
  // Second word wraps modulo the array depth.
  assign idx1 = idx0 + AW'(1);
  assign rd0  = mem_q[idx0];
  assign rd1  = mem_q[idx1];
  assign last = (cnt_q == CW'(1));

  assign split = ({2'b00, off} + {1'b0, size_q}) > 4'd4;

  always_comb begin
    lanes = 4'b0000;
    unique case (1'b1)
      (size_q == 3'd1): lanes = 4'b0001;
      (size_q == 3'd2): lanes = 4'b0011;
      (size_q == 3'd4): lanes = 4'b1111;
      default:          lanes = 4'b0000;
    endcase
  end

  // Lanes and data spread across a two-word window; the upper
  // half lands in the next word for split accesses.
  assign be8  = {4'b0000, lanes} << off;
  assign wd64 = {32'b0, wdata_q} << {off, 3'b000};

  function automatic logic [31:0] extract(
    input logic [63:0] pair,
    input logic [1:0]  o,
    input logic [2:0]  sz,
    input logic        sx
  );
    logic [63:0] sh;
    logic [31:0] w;
    sh = pair >> {o, 3'b000};
    w  = sh[31:0];
    if (sz == 3'd1) begin
      return {{24{sx & w[7]}}, w[7:0]};
    end else if (sz == 3'd2) begin
      return {{16{sx & w[15]}}, w[15:0]};
    end
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    inv_d   = inv_q;
    hold_d  = hold_q;
    rdata_d = rdata_q;
    wr0     = 1'b0;
    wr1     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          sign_d  = sign;
          wdata_d = wdata;
          ld_d    = load_mem;
          inv_d   = inv_in;
          cnt_d   = CW'(LATENCY);
          state_d = inv_in ? DONE : ACC0;
        end
      end
      ACC0: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          if (ld_q) begin
            hold_d = rd0;
            if (!split) begin
              rdata_d = extract({32'b0, rd0}, off, size_q, sign_q);
            end
          end else begin
            wr0 = 1'b1;
          end
          if (split) begin
            cnt_d   = CW'(LATENCY);
            state_d = ACC1;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACC1: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          if (ld_q) begin
            rdata_d = extract({rd1, hold_q}, off, size_q, sign_q);
          end else begin
            wr1 = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      ld_q    <= 1'b0;
      inv_q   <= 1'b0;
      hold_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      inv_q   <= inv_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wr0 && be8[i]) begin
          mem_q[idx0][8*i +: 8] <= wd64[8*i +: 8];
        end
        if (wr1 && be8[4+i]) begin
          mem_q[idx1][8*i +: 8] <= wd64[32+8*i +: 8];
        end
      end
    end
  end

  assign busy  = ((state_q == IDLE) & req)
               | (state_q == ACC0)
               | (state_q == ACC1);
  assign done  = (state_q == DONE);
  assign err   = (state_q == DONE) & inv_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Directed vectors; a monitor checks every done pulse against a queue.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        load_mem;
  logic        store_mem;
  logic [2:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_mem(load_mem),
    .store_mem(store_mem),
    .size(size),
    .sign(sign),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .err(err),
    .rdata(rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_chk;
  int          n_fail;
  int          cyc;
  logic [31:0] exp_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_err", {31'b0, err}, {31'b0, e.err});
        check("done_rdata", rdata, e.rd);
        check("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic do_req(input logic ld, input logic st,
                        input logic [2:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd,
                        input int lat);
    exp_t e;
    int   nb;
    bit   got;
    @(negedge clk);
    load_mem  = ld;
    store_mem = st;
    size      = sz;
    sign      = sx;
    addr      = a;
    wdata     = wd;
    if (ld && !st && !e_err) exp_last = e_rd;
    e.err = e_err;
    e.rd  = exp_last;
    e.due = cyc + lat;
    sb.push_back(e);
    nb  = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy) nb++;
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    load_mem  = 1'b0;
    store_mem = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done expected done within 40 cycles");
    end
    check("busy_cycles", nb, lat);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    cyc       = 0;
    exp_last  = 32'h0;
    rst       = 1'b1;
    load_mem  = 1'b0;
    store_mem = 1'b0;
    size      = 3'd4;
    sign      = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;

    // Aligned word store/load
    do_req(0, 1, 4, 0, 32'h10, 32'hDEADBEEF, 0, 0, 3);
    do_req(1, 0, 4, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3);

    // Sub-word loads with extension
    do_req(1, 0, 1, 1, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 3);
    do_req(1, 0, 1, 0, 32'h13, 32'h0, 0, 32'h000000DE, 3);
    do_req(1, 0, 2, 1, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 3);
    do_req(1, 0, 2, 0, 32'h10, 32'h0, 0, 32'h0000BEEF, 3);
    do_req(1, 0, 1, 1, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 3);

    // Misaligned word store split over two words
    do_req(0, 1, 4, 0, 32'h20, 32'h0, 0, 0, 3);
    do_req(0, 1, 4, 0, 32'h24, 32'h0, 0, 0, 3);
    do_req(0, 1, 4, 0, 32'h21, 32'h44332211, 0, 0, 5);
    do_req(1, 0, 4, 0, 32'h20, 32'h0, 0, 32'h33221100, 3);
    do_req(1, 0, 4, 0, 32'h24, 32'h0, 0, 32'h00000044, 3);
    do_req(1, 0, 4, 0, 32'h21, 32'h0, 0, 32'h44332211, 5);

    // Half store wrapping from word 255 to word 0
    do_req(0, 1, 2, 0, 32'h3FF, 32'h0000BBAA, 0, 0, 5);
    do_req(1, 0, 2, 0, 32'h3FF, 32'h0, 0, 32'h0000BBAA, 5);
    do_req(1, 0, 1, 0, 32'h3FF, 32'h0, 0, 32'h000000AA, 3);
    do_req(1, 0, 1, 0, 32'h000, 32'h0, 0, 32'h000000BB, 3);
    do_req(1, 0, 2, 1, 32'h3FF, 32'h0, 0, 32'hFFFFBBAA, 5);

    // Invalid requests: err pulse, rdata and array untouched
    do_req(1, 0, 3, 0, 32'h10, 32'h0, 1, 0, 1);
    do_req(1, 1, 4, 0, 32'h10, 32'h12345678, 1, 0, 1);
    do_req(0, 1, 0, 0, 32'h10, 32'h12345678, 1, 0, 1);
    do_req(1, 0, 4, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3);

    // Reset during the second half of a split store
    do_req(0, 1, 4, 0, 32'h30, 32'h0, 0, 0, 3);
    do_req(0, 1, 4, 0, 32'h34, 32'hCAFEF00D, 0, 0, 3);
    @(negedge clk);
    load_mem  = 1'b0;
    store_mem = 1'b1;
    size      = 3'd4;
    addr      = 32'h31;
    wdata     = 32'h44332211;
    repeat (4) @(negedge clk);
    check("acc1_busy", {31'b0, busy}, 32'h1);
    rst       = 1'b1;
    store_mem = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    rst      = 1'b0;
    exp_last = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_done", {31'b0, done}, 32'h0);
      check("idle_busy", {31'b0, busy}, 32'h0);
    end
    do_req(1, 0, 4, 0, 32'h30, 32'h0, 0, 32'h33221100, 3);
    do_req(1, 0, 4, 0, 32'h34, 32'h0, 0, 32'hCAFEF00D, 3);

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's memory-control interface.
- Consumes the level signals load_mem, store_mem, size and sign, plus the address and store data from the EX/MEM stage.
- Performs the access against an internal word-wide array with fixed multi-cycle latency and returns aligned, sign- or zero-extended load data.
- Raises busy so the pipeline holds the request; misaligned accesses are split into two word operations.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array. Power of two.
- LATENCY, 2: cycles per internal word operation. Must be 1 or greater.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- load_mem  input  1  load request level; held by the pipeline while busy
- store_mem  input  1  store request level; held while busy
- size  input  3  access size: 1 = byte, 2 = half, 4 = word; any other value is invalid
- sign  input  1  load extension: 1 = sign-extend, 0 = zero-extend; ignored for stores
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned (bits [8*size-1:0] significant)
- busy  output  1  stall request to the pipeline (combinational)
- done  output  1  one-cycle pulse: access complete
- err  output  1  one-cycle pulse with done: request was invalid
- rdata  output  32  load result, extended; held until the next done

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset:
  - state goes to IDLE; rdata=0, done=0, err=0.
  - The array is not cleared.
  - Reset during any state aborts the operation; no done is produced.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored. Offset o = addr[1:0].
- Split condition: o + size > 4, i.e. half at o=3, or word at o≠0.
  - The second word index is index+1 modulo DEPTH_WORDS, so the last word wraps to word 0.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - A request is present when load_mem or store_mem is 1.
  - On a request: capture addr, size, sign, wdata and the request type; go to ACC0 with latency counter = LATENCY.
- ACC0:
  - Decrement the counter each cycle; on its last cycle perform word operation 0.
  - Store: write the enabled lanes of word index, lanes o up to min(3, o+size-1), taking bytes from wdata starting at byte 0.
  - Load: capture word index into a holding register.
  - Next state is ACC1 (counter reloaded to LATENCY) if split, otherwise DONE.
- ACC1:
  - On its last cycle, write the remaining lanes 0 up to (o+size-5) of word index+1, continuing with the next wdata bytes; or, for a load, capture that word.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Load: rdata = the selected bytes assembled little-endian. Byte/half is sign-extended when sign=1, zero-extended otherwise. A word is unmodified.
  - Store: rdata is unchanged.
  - Always go to IDLE. A request seen during DONE is the same one and is not re-accepted.
- busy = (IDLE and request present) or ACC0 or ACC1. busy is 0 in DONE so the pipeline advances on that edge.
- Latency, with acceptance in cycle T:
  - Aligned access: done in cycle T+1+LATENCY.
  - Split access: done in cycle T+1+2*LATENCY.
- Invalid request:
  - Conditions: size not 1, 2 or 4, or load_mem and store_mem both 1.
  - The request is accepted, then goes straight to DONE the next cycle with done=1 and err=1.
  - No array write; rdata is unchanged.
- Split store with reset during ACC1: the word-0 lanes are already written and stay written; word index+1 is untouched. This is defined behaviour.
- Back-to-back requests are allowed with one IDLE cycle between them (the DONE to IDLE transition).

Test Plan:
1. LATENCY=2. SW addr 0x10, wdata 0xDEADBEEF, then LW addr 0x10 -> store done at T+3 with busy=1 for T..T+2; load done at T'+3 with rdata=0xDEADBEEF and err=0.
2. Word 0x10 = 0xDEADBEEF. LB addr 0x13 sign=1 -> rdata=0xFFFFFFDE. LBU addr 0x13 -> 0x000000DE. LH addr 0x12 sign=1 -> 0xFFFFDEAD.
3. Misaligned SW addr 0x21, wdata 0x44332211, words 0x20 and 0x24 pre-zeroed -> done at T+5; word 0x20 reads 0x33221100 and word 0x24 reads 0x00000044. LW addr 0x21 -> rdata 0x44332211 with done at T+5.
4. Wrap-around: DEPTH_WORDS=256, SH addr 0x3FF, wdata 0xBBAA -> lane 3 of word 255 = 0xAA and lane 0 of word 0 = 0xBB. LHU addr 0x3FF -> 0x0000BBAA.
5. Invalid: load_mem=1, size=3 -> done and err pulse at T+1, no array change, rdata unchanged. load_mem=store_mem=1 -> same response.
6. Reset mid-op: split SW addr 0x31, wdata 0x44332211; assert rst during ACC1 -> no done; state IDLE; busy=0 with no request; word 0x30 reads 0x33221100 and word 0x34 is unchanged.
